operand_fetch: RTL



---
 rtl/gDefine.sv | 24 ++
 rtl/vec_strb_merge.sv | 24 ++
 rtl/operand_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gDefine.sv
// Shared vector/register-file definitions for the operand-fetch path.
// Depth, tag width and vector geometry live here so every client of the
// register RAM agrees on them.
package gDefine;

    localparam int VEC_WIDTH = 8;               // lanes per vector
    localparam int LANE_W    = 8;               // bits per lane
    localparam int SIZE      = 2048;            // register RAM depth (entries)
    localparam int SIZE_L    = $clog2(SIZE);    // register address width
    localparam int TAG_W     = 6;               // request tag width
    localparam int N_RD      = 3;               // RAM read ports / operands

    typedef logic [VEC_WIDTH-1:0][LANE_W-1:0] Vector_t;
    typedef logic [VEC_WIDTH-1:0]             Mask_t;
    typedef logic [SIZE_L-1:0]                Addr_t;
    typedef logic [TAG_W-1:0]                 Tag_t;

    // One operand-fetch request: three source registers plus an opaque tag.
    typedef struct packed {
        Addr_t [N_RD-1:0] addr;
        Tag_t             tag;
    } OpReq_t;

endpackage

// File: rtl/vec_strb_merge.sv
// Lane-wise patch of a vector: every lane whose strobe bit is set takes the
// patch value, provided the merge is enabled at all.
module vec_strb_merge
    import gDefine::*;
(
    input  Vector_t i_base,
    input  Vector_t i_patch,
    input  Mask_t   i_strb,
    input  logic    i_en,
    output Vector_t o_vec
);

    // Start from the base vector and overwrite strobed lanes.
    always_comb begin
        // NOTE: the unconditional default keeps every path assigned, so no latch is inferred.
        o_vec = i_base;
        for (int l = 0; l < VEC_WIDTH; l++) begin
            if (i_en && i_strb[l]) begin
                o_vec[l] = i_patch[l];
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Read-side client of the 3R/1W strobed vector register RAM.
// Two stages: S1 waits out the RAM's registered read, OUT presents the
// operands. Writes seen on the RAM write port are forwarded lane by lane
// so the operands handed to the consumer are never stale.
module operand_fetch
    import gDefine::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SIZE_L-1:0] req_addr0,
    input  logic [SIZE_L-1:0] req_addr1,
    input  logic [SIZE_L-1:0] req_addr2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [SIZE_L-1:0] ram_addr0,
    output logic [SIZE_L-1:0] ram_addr1,
    output logic [SIZE_L-1:0] ram_addr2,
    input  Vector_t           ram_d0,
    input  Vector_t           ram_d1,
    input  Vector_t           ram_d2,
    input  logic              wb_wen,
    input  logic [SIZE_L-1:0] wb_waddr,
    input  Vector_t           wb_din,
    input  Mask_t             wb_strb,
    output logic              out_valid,
    input  logic              out_ready,
    output Vector_t           out_op0,
    output Vector_t           out_op1,
    output Vector_t           out_op2,
    output logic [TAG_W-1:0]  out_tag
);

    OpReq_t          w_req;
    Vector_t         w_ram_d    [N_RD];
    Addr_t           w_ram_addr [N_RD];
    Vector_t         w_fwd_op   [N_RD];
    Vector_t         w_s1_op    [N_RD];
    Vector_t         w_hold_op  [N_RD];
    logic            w_s1_adv;
    logic            w_s1_load;

    logic            r_s1_valid;
    OpReq_t          r_s1;
    logic            r_out_valid;
    Vector_t         r_out_op   [N_RD];
    Addr_t           r_out_addr [N_RD];
    Tag_t            r_out_tag;
    logic [N_RD-1:0] r_fw_hit;
    Vector_t         r_fw_din;
    Mask_t           r_fw_strb;

    assign w_req.addr[0] = req_addr0;
    assign w_req.addr[1] = req_addr1;
    assign w_req.addr[2] = req_addr2;
    assign w_req.tag     = req_tag;

    assign w_ram_d[0] = ram_d0;
    assign w_ram_d[1] = ram_d1;
    assign w_ram_d[2] = ram_d2;

    // S1 may move on whenever OUT is empty or being drained this cycle.
    assign w_s1_adv  = !r_out_valid || out_ready;
    assign w_s1_load = r_s1_valid && w_s1_adv;
    assign req_ready = !r_s1_valid || w_s1_adv;

    // Per-port address steering and the three merge points of each operand.
    for (genvar g = 0; g < N_RD; g++) begin : g_port
        // A stalled S1 keeps re-reading its own address so its data stays fresh.
        assign w_ram_addr[g] = (r_s1_valid && !w_s1_adv) ? r_s1.addr[g] : w_req.addr[g];

        // Patch in last cycle's write, which the RAM read could not see.
        vec_strb_merge u_fwd (
            .i_base  (w_ram_d[g]),
            .i_patch (r_fw_din),
            .i_strb  (r_fw_strb),
            .i_en    (r_fw_hit[g]),
            .o_vec   (w_fwd_op[g])
        );

        // Patch in this cycle's write; it is newer than the forwarded one.
        vec_strb_merge u_s1_live (
            .i_base  (w_fwd_op[g]),
            .i_patch (wb_din),
            .i_strb  (wb_strb),
            .i_en    (wb_wen && (wb_waddr == r_s1.addr[g])),
            .o_vec   (w_s1_op[g])
        );

        // Keep held output operands current while the consumer stalls.
        vec_strb_merge u_out_live (
            .i_base  (r_out_op[g]),
            .i_patch (wb_din),
            .i_strb  (wb_strb),
            .i_en    (wb_wen && (wb_waddr == r_out_addr[g])),
            .o_vec   (w_hold_op[g])
        );
    end

    assign ram_addr0 = w_ram_addr[0];
    assign ram_addr1 = w_ram_addr[1];
    assign ram_addr2 = w_ram_addr[2];

    // Record each cycle's write against the addresses being read this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fw_hit  <= '0;
            r_fw_din  <= '0;
            r_fw_strb <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values.
            for (int i = 0; i < N_RD; i++) begin
                r_fw_hit[i] <= wb_wen && (wb_waddr == w_ram_addr[i]);
            end
            r_fw_din  <= wb_din;
            r_fw_strb <= wb_strb;
        end
    end

    // S1: capture a new request whenever the stage is free to accept one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (req_ready) begin
            r_s1_valid <= req_valid;
            r_s1       <= w_req;
        end
    end

    // OUT: load from S1, merge live writes while held, drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            // NOTE: only three vector registers, so clearing them in reset is cheap and gives a defined idle output.
            for (int i = 0; i < N_RD; i++) begin
                r_out_op[i]   <= '0;
                r_out_addr[i] <= '0;
            end
        end else if (w_s1_load) begin
            r_out_valid <= 1'b1;
            r_out_tag   <= r_s1.tag;
            for (int i = 0; i < N_RD; i++) begin
                r_out_op[i]   <= w_s1_op[i];
                r_out_addr[i] <= r_s1.addr[i];
            end
        end else if (r_out_valid && !out_ready) begin
            for (int i = 0; i < N_RD; i++) begin
                r_out_op[i] <= w_hold_op[i];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_op0   = r_out_op[0];
    assign out_op1   = r_out_op[1];
    assign out_op2   = r_out_op[2];

endmodule
